// File: rtl/sar_search_4bit_if.sv
// Interface bundling the search handshake and the external comparator link
// for sar_search_4bit. master = requester/comparator side, slave = search engine.
interface sar_search_4bit_if;
  logic       start;
  logic [3:0] A;
  logic       E;
  logic       G;
  logic       L;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] result;
  logic [2:0] probes;
  logic       err;

  modport master (
    output start, E, G, L,
    input  A, busy, done, found, result, probes, err
  );

  modport slave (
    input  start, E, G, L,
    output A, busy, done, found, result, probes, err
  );
endinterface

// File: rtl/sar_search_4bit.sv
// sar_search_4bit: successive-approximation search for an unknown 4-bit value
// through an external comparator (A is probed, E/G/L report A==B, A>B, A<B).
// One probe per cycle, at most five probes per search.
// Optional macro SAR_FLAG_CHECK_EN: flags that are not exactly one-hot abort the
// search with err=1. Without it err is always 0 and flags decode as E > G > L,
// with an all-zero flag set treated as L.
module sar_search_4bit (
  input logic              clk,
  input logic              rst,
  sar_search_4bit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] lo_q, lo_d;
  logic [4:0] hi_q, hi_d;
  logic [3:0] a_q, a_d;
  logic [3:0] result_q, result_d;
  logic [2:0] probes_q, probes_d;
  logic       found_q, found_d;
  logic       err_q, err_d;

  logic       f_eq;
  logic       f_gt;
  logic       f_bad;
  logic [4:0] lo_n;
  logic [4:0] hi_n;
  logic       empty;

  // Comparator flag decode into equal / greater / protocol-error terms
  always_comb begin
`ifdef SAR_FLAG_CHECK_EN
    f_bad = !((bus.E ^ bus.G ^ bus.L) && !(bus.E && bus.G && bus.L));
    f_eq  = bus.E;
    f_gt  = bus.G;
`else
    f_bad = 1'b0;
    f_eq  = bus.E;
    f_gt  = !bus.E && bus.G;
`endif
  end

  // Next-state, bound update and probe selection
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    a_d      = a_q;
    result_d = result_q;
    probes_d = probes_q;
    found_d  = found_q;
    err_d    = err_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    empty    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lo_d     = '0;
          hi_d     = 5'd15;
          a_d      = 4'd7;
          probes_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = PROBE;
        end
      end

      PROBE: begin
        probes_d = probes_q + 3'd1;
        if (f_bad) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else if (f_eq) begin
          result_d = a_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else begin
          // A=0 with G would wrap hi to 31, so that case is flagged explicitly
          if (f_gt) begin
            hi_n  = {1'b0, a_q} - 5'd1;
            empty = (a_q == 4'd0) || (lo_q > hi_n);
          end else begin
            lo_n  = {1'b0, a_q} + 5'd1;
            empty = lo_n > hi_q;
          end
          lo_d = lo_n;
          hi_d = hi_n;
          if (empty || (probes_q == 3'd4)) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            a_d = 4'((lo_n + hi_n) >> 1);
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      a_q      <= '0;
      result_q <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      a_q      <= a_d;
      result_q <= result_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign bus.A      = a_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.found  = found_q;
  assign bus.result = result_q;
  assign bus.probes = probes_q;
`ifdef SAR_FLAG_CHECK_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search_4bit.sv
// Self-checking bench for sar_search_4bit: an integer binary-search model
// predicts every probe and the final outcome; a negedge compare process checks
// the DUT each cycle against it.
module tb_sar_search_4bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_search_4bit_if bus();

  sar_search_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // stimulus / model state
  int         mode;        // 0 correct comparator, 1 always G, 2 flag table
  int         tgt;
  logic [2:0] ftab [5];
  int         exp_a [5];
  int         exp_n;
  int         exp_found;
  int         exp_err;
  int         exp_res;
  int         last_res;

  // values the DUT must hold while idle
  int hold_a, hold_found, hold_res, hold_probes, hold_err;

  bit chk_en = 1'b0;
  bit active = 1'b0;
  int k = 0;

  function automatic logic [2:0] flags_for(input int m, input int idx, input int a);
    logic [2:0] f;
    case (m)
      0:       f = {a == tgt, a > tgt, a < tgt};
      1:       f = 3'b010;
      default: f = ftab[idx];
    endcase
    return f;
  endfunction

  // Plain binary search over integers using the comparator's answers
  task automatic model();
    int lo, hi, a, n, fnd, er, res;
    logic [2:0] f;
    lo = 0; hi = 15; a = 7; n = 0; fnd = 0; er = 0; res = last_res;
    for (int i = 0; i < 5; i++) begin
      exp_a[i] = a;
      f = flags_for(mode, i, a);
      n = i + 1;
`ifdef SAR_FLAG_CHECK_EN
      if ($countones(f) != 1) begin er = 1; break; end
`endif
      if (f[2]) begin fnd = 1; res = a; break; end
      if (f[1]) hi = a - 1; else lo = a + 1;
      if (lo > hi) break;
      a = (lo + hi) / 2;
    end
    exp_n = n; exp_found = fnd; exp_err = er; exp_res = res;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (active && k >= 1 && k <= exp_n) begin
        check("busy_probe",   bus.busy,   1);
        check("done_probe",   bus.done,   0);
        check("A_probe",      bus.A,      exp_a[k-1]);
        check("probes_probe", bus.probes, k - 1);
      end else if (active && k == exp_n + 1) begin
        check("done_pulse",  bus.done,   1);
        check("busy_done",   bus.busy,   1);
        check("found_done",  bus.found,  exp_found);
        check("err_done",    bus.err,    exp_err);
        check("result_done", bus.result, exp_res);
        check("probes_done", bus.probes, exp_n);
        check("A_done",      bus.A,      exp_a[exp_n-1]);
      end else begin
        check("busy_idle",   bus.busy,   0);
        check("done_idle",   bus.done,   0);
        check("A_idle",      bus.A,      hold_a);
        check("found_idle",  bus.found,  hold_found);
        check("result_idle", bus.result, hold_res);
        check("probes_idle", bus.probes, hold_probes);
        check("err_idle",    bus.err,    hold_err);
      end
    end
  end

  task automatic run_search(input int m, input int b, input bit poke);
    mode = m; tgt = b;
    model();
    @(negedge clk);
    bus.start = 1'b1; active = 1'b1; k = 0;
    @(posedge clk);
    k = 1;
    hold_a = exp_a[exp_n-1]; hold_found = exp_found; hold_res = exp_res;
    hold_probes = exp_n; hold_err = exp_err; last_res = exp_res;
    for (int j = 0; j < exp_n + 2; j++) begin
      @(negedge clk);
      bus.start = poke && (k == 1 || k == exp_n + 1);
      if (k <= exp_n) {bus.E, bus.G, bus.L} = flags_for(mode, k - 1, bus.A);
      else            {bus.E, bus.G, bus.L} = 3'b000;
      @(posedge clk);
      k++;
    end
    active = 1'b0;
  endtask

  task automatic pin_seq(input string name, input int n, input int a0, input int a1,
                         input int a2, input int a3, input int a4);
    int want [5];
    want = '{a0, a1, a2, a3, a4};
    check({name, "_n"}, exp_n, n);
    for (int i = 0; i < n; i++) check({name, "_a"}, exp_a[i], want[i]);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.E = 1'b0; bus.G = 1'b0; bus.L = 1'b0;
    for (int i = 0; i < 5; i++) ftab[i] = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_A", bus.A, 0);           check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);     check("rst_found", bus.found, 0);
    check("rst_result", bus.result, 0); check("rst_probes", bus.probes, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    hold_a = 0; hold_found = 0; hold_res = 0; hold_probes = 0; hold_err = 0;
    last_res = 0;
    chk_en = 1'b1;

    // directed searches with the model pinned to hand-derived answers
    run_search(0, 9, 1'b0);
    pin_seq("b9", 3, 7, 11, 9, 0, 0);
    check("b9_found", exp_found, 1); check("b9_res", exp_res, 9);

    run_search(0, 15, 1'b1);
    pin_seq("b15", 5, 7, 11, 13, 14, 15);
    check("b15_found", exp_found, 1);

    run_search(0, 0, 1'b0);
    pin_seq("b0", 4, 7, 3, 1, 0, 0);
    check("b0_found", exp_found, 1); check("b0_res", exp_res, 0);

    run_search(1, 5, 1'b1);
    pin_seq("allg", 4, 7, 3, 1, 0, 0);
    check("allg_found", exp_found, 0);

    ftab[0] = 3'b110;
    run_search(2, 0, 1'b0);
    check("f110_n", exp_n, 1);
`ifdef SAR_FLAG_CHECK_EN
    check("f110_err", exp_err, 1); check("f110_found", exp_found, 0);
`else
    check("f110_found", exp_found, 1); check("f110_res", exp_res, 7);
`endif

    // abort by reset mid-search, with an ignored start during PROBE
    chk_en = 1'b0; mode = 0; tgt = 9;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ab_A1", bus.A, 7); check("ab_busy1", bus.busy, 1);
    bus.start = 1'b1; {bus.E, bus.G, bus.L} = flags_for(0, 0, bus.A);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("ab_A2", bus.A, 11); check("ab_busy2", bus.busy, 1);
    check("ab_probes2", bus.probes, 1);
    {bus.E, bus.G, bus.L} = flags_for(0, 1, bus.A);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; {bus.E, bus.G, bus.L} = 3'b000;
    check("ab_A", bus.A, 0);           check("ab_busy", bus.busy, 0);
    check("ab_done", bus.done, 0);     check("ab_found", bus.found, 0);
    check("ab_result", bus.result, 0); check("ab_probes", bus.probes, 0);
    check("ab_err", bus.err, 0);
    hold_a = 0; hold_found = 0; hold_res = 0; hold_probes = 0; hold_err = 0;
    last_res = 0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // randomized searches
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 5; i++) ftab[i] = 3'($urandom_range(0, 7));
      run_search(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
